issue_ctrl: RTL and testbench

//  Issue sequencer between the instruction queue and the reorder buffer. Pops one decoded instruction,

---
 rtl/issue_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_issue_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_ctrl.sv
// ============================================================================
//  Module      : issue_ctrl
//  Description : Instruction issue sequencer. Pops one decoded instruction,
//                reserves a ROB slot, resolves its operands, then dispatches
//                it to the ROB and to the RS or LSB, locking rd in the regfile.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module issue_ctrl #(
  parameter int ROB_W     = 4,
  parameter int LSB_W     = 4,
  parameter int OP_W      = 6,
  // Internal opcodes in [BR_OP_MIN, BR_OP_MAX] are conditional branches (no rd write)
  parameter int BR_OP_MIN = 10,
  parameter int BR_OP_MAX = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ready,
  input  logic             clear,

  input  logic             iq_valid,
  input  logic [OP_W-1:0]  iq_op,
  input  logic [4:0]       iq_rd,
  input  logic [4:0]       iq_rs1,
  input  logic [4:0]       iq_rs2,
  input  logic [31:0]      iq_imm,
  input  logic [31:0]      iq_pc,
  input  logic             iq_is_mem,
  input  logic             iq_is_store,
  output logic             iq_pop,

  input  logic             rob_full,
  output logic             getpos,
  input  logic [ROB_W-1:0] rob_avail_pos,

  output logic [4:0]       rf_rs1_idx,
  output logic [4:0]       rf_rs2_idx,
  input  logic             rf_rs1_busy,
  input  logic [ROB_W-1:0] rf_rs1_robpos,
  input  logic [31:0]      rf_rs1_val,
  input  logic             rf_rs2_busy,
  input  logic [ROB_W-1:0] rf_rs2_robpos,
  input  logic [31:0]      rf_rs2_val,

  output logic             rs1_flag,
  output logic [ROB_W-1:0] rs1_robpos,
  input  logic             rs1_ok,
  input  logic [31:0]      rs1_val,
  output logic             rs2_flag,
  output logic [ROB_W-1:0] rs2_robpos,
  input  logic             rs2_ok,
  input  logic [31:0]      rs2_val,

  input  logic             alu_flag,
  input  logic [ROB_W-1:0] alu_robpos,
  input  logic [31:0]      alu_val,
  input  logic             lsb_in_flag,
  input  logic [ROB_W-1:0] lsb_robpos,
  input  logic [31:0]      lsb_val,

  input  logic             rs_full,
  input  logic             lsb_full,
  input  logic [LSB_W-1:0] lsb_tail,

  output logic             push,
  output logic [OP_W-1:0]  push_op,
  output logic [4:0]       push_rd,
  output logic [31:0]      push_pc,
  output logic [LSB_W-1:0] push_lsbpos,

  output logic             rs_push,
  output logic             lsb_push,
  output logic [OP_W-1:0]  issue_op,
  output logic             issue_is_store,
  output logic [31:0]      issue_vj,
  output logic [ROB_W-1:0] issue_qj,
  output logic             issue_rj,
  output logic [31:0]      issue_vk,
  output logic [ROB_W-1:0] issue_qk,
  output logic             issue_rk,
  output logic [31:0]      issue_imm,
  output logic [31:0]      issue_pc,
  output logic [ROB_W-1:0] issue_robpos,

  output logic             lock,
  output logic [4:0]       lock_rd,
  output logic [ROB_W-1:0] lock_robpos
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RESOLVE = 2'd1,
    S_ISSUE   = 2'd2
  } state_t;

  typedef struct packed {
    logic             rdy;
    logic [31:0]      val;
    logic [ROB_W-1:0] tag;
  } opnd_t;

  // Regfile / ROB-forward lookup of one source register
  function automatic opnd_t lookup(
    input logic [4:0]       rs,
    input logic             busy,
    input logic [ROB_W-1:0] rf_tag,
    input logic [31:0]      rf_val,
    input logic             fw_ok,
    input logic [31:0]      fw_val
  );
    opnd_t r;
    r = '0;
    if (rs == 5'd0) begin
      r.rdy = 1'b1;
    end else if (!busy) begin
      r.rdy = 1'b1;
      r.val = rf_val;
    end else if (fw_ok) begin
      r.rdy = 1'b1;
      r.val = fw_val;
    end else begin
      r.tag = rf_tag;
    end
    return r;
  endfunction

  // Capture a same-cycle result broadcast; the ALU port takes precedence
  function automatic opnd_t snoop(
    input opnd_t            o,
    input logic             a_flag,
    input logic [ROB_W-1:0] a_tag,
    input logic [31:0]      a_val,
    input logic             l_flag,
    input logic [ROB_W-1:0] l_tag,
    input logic [31:0]      l_val
  );
    opnd_t r;
    r = o;
    if (!o.rdy) begin
      if (a_flag && (a_tag == o.tag)) begin
        r.rdy = 1'b1;
        r.val = a_val;
      end else if (l_flag && (l_tag == o.tag)) begin
        r.rdy = 1'b1;
        r.val = l_val;
      end
    end
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [4:0]        rs1_q, rs1_d;
  logic [4:0]        rs2_q, rs2_d;
  logic [31:0]       imm_q, imm_d;
  logic [31:0]       pc_q, pc_d;
  logic              is_mem_q, is_mem_d;
  logic              is_store_q, is_store_d;
  logic [ROB_W-1:0]  robpos_q, robpos_d;
  logic [LSB_W-1:0]  lsbpos_q, lsbpos_d;
  opnd_t             j_q, j_d;
  opnd_t             k_q, k_d;

  logic              w_go;
  logic              w_tgt_full;
  logic              w_issue;
  logic              w_is_branch;
  opnd_t             w_j_res, w_k_res;
  opnd_t             w_j_iss, w_k_iss;

  // Strobes need ready, no flush, and no reset in progress
  assign w_go       = ready && !clear && !reset;
  assign w_tgt_full = iq_is_mem ? lsb_full : rs_full;
  assign w_issue    = w_go && (state_q == S_ISSUE);
  assign w_is_branch = (op_q >= OP_W'(BR_OP_MIN)) && (op_q <= OP_W'(BR_OP_MAX));

  assign iq_pop     = w_go && (state_q == S_IDLE) && iq_valid && !rob_full && !w_tgt_full;
  assign getpos     = w_go && (state_q == S_RESOLVE);

  assign rf_rs1_idx = rs1_q;
  assign rf_rs2_idx = rs2_q;
  assign rs1_flag   = getpos && (rs1_q != 5'd0) && rf_rs1_busy;
  assign rs2_flag   = getpos && (rs2_q != 5'd0) && rf_rs2_busy;
  assign rs1_robpos = rf_rs1_robpos;
  assign rs2_robpos = rf_rs2_robpos;

  always_comb begin
    w_j_res = snoop(lookup(rs1_q, rf_rs1_busy, rf_rs1_robpos, rf_rs1_val, rs1_ok, rs1_val),
                    alu_flag, alu_robpos, alu_val, lsb_in_flag, lsb_robpos, lsb_val);
    w_k_res = snoop(lookup(rs2_q, rf_rs2_busy, rf_rs2_robpos, rf_rs2_val, rs2_ok, rs2_val),
                    alu_flag, alu_robpos, alu_val, lsb_in_flag, lsb_robpos, lsb_val);
    w_j_iss = snoop(j_q, alu_flag, alu_robpos, alu_val, lsb_in_flag, lsb_robpos, lsb_val);
    w_k_iss = snoop(k_q, alu_flag, alu_robpos, alu_val, lsb_in_flag, lsb_robpos, lsb_val);
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    imm_d      = imm_q;
    pc_d       = pc_q;
    is_mem_d   = is_mem_q;
    is_store_d = is_store_q;
    robpos_d   = robpos_q;
    lsbpos_d   = lsbpos_q;
    j_d        = j_q;
    k_d        = k_q;
    if (clear) begin
      state_d = S_IDLE;
    end else if (ready) begin
      case (state_q)
        S_IDLE: begin
          if (iq_pop) begin
            op_d       = iq_op;
            rd_d       = iq_rd;
            rs1_d      = iq_rs1;
            rs2_d      = iq_rs2;
            imm_d      = iq_imm;
            pc_d       = iq_pc;
            is_mem_d   = iq_is_mem;
            is_store_d = iq_is_store;
            state_d    = S_RESOLVE;
          end
        end
        S_RESOLVE: begin
          robpos_d = rob_avail_pos;
          lsbpos_d = lsb_tail;
          j_d      = w_j_res;
          k_d      = w_k_res;
          state_d  = S_ISSUE;
        end
        S_ISSUE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      is_mem_q   <= 1'b0;
      is_store_q <= 1'b0;
      robpos_q   <= '0;
      lsbpos_q   <= '0;
      j_q        <= '0;
      k_q        <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
      is_mem_q   <= is_mem_d;
      is_store_q <= is_store_d;
      robpos_q   <= robpos_d;
      lsbpos_q   <= lsbpos_d;
      j_q        <= j_d;
      k_q        <= k_d;
    end
  end

  assign push           = w_issue;
  assign push_op        = op_q;
  assign push_rd        = rd_q;
  assign push_pc        = pc_q;
  assign push_lsbpos    = lsbpos_q;

  assign rs_push        = w_issue && !is_mem_q;
  assign lsb_push       = w_issue && is_mem_q;
  assign issue_op       = op_q;
  assign issue_is_store = is_store_q;
  assign issue_vj       = w_j_iss.val;
  assign issue_rj       = w_j_iss.rdy;
  assign issue_qj       = w_j_iss.rdy ? '0 : w_j_iss.tag;
  assign issue_vk       = w_k_iss.val;
  assign issue_rk       = w_k_iss.rdy;
  assign issue_qk       = w_k_iss.rdy ? '0 : w_k_iss.tag;
  assign issue_imm      = imm_q;
  assign issue_pc       = pc_q;
  assign issue_robpos   = robpos_q;

  // Stores and conditional branches write no register; jumps do
  assign lock        = w_issue && (rd_q != 5'd0) && !(is_mem_q && is_store_q) && !w_is_branch;
  assign lock_rd     = rd_q;
  assign lock_robpos = robpos_q;

endmodule

`default_nettype wire

// File: tb/tb_issue_ctrl.sv
// ============================================================================
//  Module      : tb_issue_ctrl
//  Description : Self-checking bench for issue_ctrl: hand-written vectors,
//                random issues against a reference model, and corner sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_issue_ctrl;
  localparam logic [5:0] OP_ADDI = 6'd20, OP_ADD = 6'd21, OP_SW = 6'd30, OP_LW = 6'd31;
  localparam logic [5:0] OP_BEQ = 6'd10, OP_JALR = 6'd17;

  logic clk, reset, ready, clear;
  logic iq_valid, iq_is_mem, iq_is_store, iq_pop;
  logic [5:0] iq_op;
  logic [4:0] iq_rd, iq_rs1, iq_rs2;
  logic [31:0] iq_imm, iq_pc;
  logic rob_full, getpos;
  logic [3:0] rob_avail_pos;
  logic [4:0] rf_rs1_idx, rf_rs2_idx;
  logic rf_rs1_busy, rf_rs2_busy;
  logic [3:0] rf_rs1_robpos, rf_rs2_robpos;
  logic [31:0] rf_rs1_val, rf_rs2_val;
  logic rs1_flag, rs2_flag, rs1_ok, rs2_ok;
  logic [3:0] rs1_robpos, rs2_robpos;
  logic [31:0] rs1_val, rs2_val;
  logic alu_flag, lsb_in_flag;
  logic [3:0] alu_robpos, lsb_robpos;
  logic [31:0] alu_val, lsb_val;
  logic rs_full, lsb_full;
  logic [3:0] lsb_tail;
  logic push, rs_push, lsb_push, lock;
  logic [5:0] push_op, issue_op;
  logic [4:0] push_rd, lock_rd;
  logic [31:0] push_pc, issue_vj, issue_vk, issue_imm, issue_pc;
  logic [3:0] push_lsbpos, issue_qj, issue_qk, issue_robpos, lock_robpos;
  logic issue_is_store, issue_rj, issue_rk;

  issue_ctrl dut (
    .clk(clk), .reset(reset), .ready(ready), .clear(clear),
    .iq_valid(iq_valid), .iq_op(iq_op), .iq_rd(iq_rd), .iq_rs1(iq_rs1), .iq_rs2(iq_rs2),
    .iq_imm(iq_imm), .iq_pc(iq_pc), .iq_is_mem(iq_is_mem), .iq_is_store(iq_is_store),
    .iq_pop(iq_pop), .rob_full(rob_full), .getpos(getpos), .rob_avail_pos(rob_avail_pos),
    .rf_rs1_idx(rf_rs1_idx), .rf_rs2_idx(rf_rs2_idx),
    .rf_rs1_busy(rf_rs1_busy), .rf_rs1_robpos(rf_rs1_robpos), .rf_rs1_val(rf_rs1_val),
    .rf_rs2_busy(rf_rs2_busy), .rf_rs2_robpos(rf_rs2_robpos), .rf_rs2_val(rf_rs2_val),
    .rs1_flag(rs1_flag), .rs1_robpos(rs1_robpos), .rs1_ok(rs1_ok), .rs1_val(rs1_val),
    .rs2_flag(rs2_flag), .rs2_robpos(rs2_robpos), .rs2_ok(rs2_ok), .rs2_val(rs2_val),
    .alu_flag(alu_flag), .alu_robpos(alu_robpos), .alu_val(alu_val),
    .lsb_in_flag(lsb_in_flag), .lsb_robpos(lsb_robpos), .lsb_val(lsb_val),
    .rs_full(rs_full), .lsb_full(lsb_full), .lsb_tail(lsb_tail),
    .push(push), .push_op(push_op), .push_rd(push_rd), .push_pc(push_pc),
    .push_lsbpos(push_lsbpos), .rs_push(rs_push), .lsb_push(lsb_push),
    .issue_op(issue_op), .issue_is_store(issue_is_store),
    .issue_vj(issue_vj), .issue_qj(issue_qj), .issue_rj(issue_rj),
    .issue_vk(issue_vk), .issue_qk(issue_qk), .issue_rk(issue_rk),
    .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_robpos(issue_robpos),
    .lock(lock), .lock_rd(lock_rd), .lock_robpos(lock_robpos)
  );

  // One issue scenario: instruction, environment, and expected dispatch.
  // Broadcast slots: 0 = ALU in RESOLVE, 1 = LSB in RESOLVE, 2 = ALU in ISSUE, 3 = LSB in ISSUE.
  typedef struct packed {
    logic [5:0] op; logic [4:0] rd, rs1, rs2; logic [31:0] imm, pc;
    logic mem, st; logic [3:0] tail, ltail;
    logic b1; logic [3:0] t1; logic [31:0] v1; logic ok1; logic [31:0] f1;
    logic b2; logic [3:0] t2; logic [31:0] v2; logic ok2; logic [31:0] f2;
    logic [3:0] bf; logic [3:0][3:0] bt; logic [3:0][31:0] bv;
    logic e_lock; logic e_rj; logic [31:0] e_vj; logic [3:0] e_qj;
    logic e_rk; logic [31:0] e_vk; logic [3:0] e_qk;
  } vec_t;

  int n_run = 0, n_fail = 0, pop_cnt = 0;
  vec_t tbl[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) if (iq_pop && !reset) pop_cnt = pop_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [5:0] op, input logic [4:0] rd, rs1, rs2,
                              input logic [31:0] imm, input logic mem, st);
    vec_t v;
    v = '0;
    v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    v.mem = mem; v.st = st; v.pc = 32'h1000 + {26'd0, op} * 4;
    return v;
  endfunction

  // Value of a source: architectural if rs is x0 or not pending, otherwise the
  // earliest producer seen (ROB already holds it, then broadcasts in time order).
  function automatic void model_src(input vec_t v, input logic [4:0] rs, input logic busy,
                                    input logic [3:0] tg, input logic [31:0] rv,
                                    input logic ok, input logic [31:0] fv,
                                    output logic rdy, output logic [31:0] val,
                                    output logic [3:0] q);
    rdy = 1'b0; val = '0; q = '0;
    if (rs == 5'd0) rdy = 1'b1;
    else if (!busy) begin rdy = 1'b1; val = rv; end
    else if (ok) begin rdy = 1'b1; val = fv; end
    else begin
      for (int i = 0; i < 4; i++)
        if (!rdy && v.bf[i] && v.bt[i] == tg) begin rdy = 1'b1; val = v.bv[i]; end
      if (!rdy) q = tg;
    end
  endfunction

  function automatic vec_t predict(input vec_t v);
    vec_t r;
    r = v;
    model_src(v, v.rs1, v.b1, v.t1, v.v1, v.ok1, v.f1, r.e_rj, r.e_vj, r.e_qj);
    model_src(v, v.rs2, v.b2, v.t2, v.v2, v.ok2, v.f2, r.e_rk, r.e_vk, r.e_qk);
    r.e_lock = (v.rd != 0) && !(v.mem && v.st) && !(v.op >= 6'd10 && v.op <= 6'd15);
    return r;
  endfunction

  task automatic scramble();
    rob_avail_pos = 4'($urandom); lsb_tail = 4'($urandom);
    rf_rs1_busy = 1'($urandom); rf_rs1_robpos = 4'($urandom); rf_rs1_val = $urandom;
    rf_rs2_busy = 1'($urandom); rf_rs2_robpos = 4'($urandom); rf_rs2_val = $urandom;
    rs1_ok = 1'($urandom); rs1_val = $urandom; rs2_ok = 1'($urandom); rs2_val = $urandom;
    alu_flag = 1'b0; alu_robpos = 4'($urandom); alu_val = $urandom;
    lsb_in_flag = 1'b0; lsb_robpos = 4'($urandom); lsb_val = $urandom;
  endtask

  task automatic drive_instr(input vec_t v);
    iq_op = v.op; iq_rd = v.rd; iq_rs1 = v.rs1; iq_rs2 = v.rs2;
    iq_imm = v.imm; iq_pc = v.pc; iq_is_mem = v.mem; iq_is_store = v.st;
  endtask

  task automatic drive_resolve(input vec_t v);
    iq_valid = 1'b0;
    iq_op = 6'($urandom); iq_rd = 5'($urandom); iq_rs1 = 5'($urandom); iq_rs2 = 5'($urandom);
    iq_imm = $urandom; iq_pc = $urandom;
    rob_avail_pos = v.tail; lsb_tail = v.ltail;
    rf_rs1_busy = v.b1; rf_rs1_robpos = v.t1; rf_rs1_val = v.v1; rs1_ok = v.ok1; rs1_val = v.f1;
    rf_rs2_busy = v.b2; rf_rs2_robpos = v.t2; rf_rs2_val = v.v2; rs2_ok = v.ok2; rs2_val = v.f2;
    alu_flag = v.bf[0]; alu_robpos = v.bt[0]; alu_val = v.bv[0];
    lsb_in_flag = v.bf[1]; lsb_robpos = v.bt[1]; lsb_val = v.bv[1];
  endtask

  task automatic check_issue(input vec_t v, input string nm);
    chk({nm, ".push"}, push, 1);
    chk({nm, ".rs_push"}, rs_push, !v.mem);
    chk({nm, ".lsb_push"}, lsb_push, v.mem);
    chk({nm, ".lock"}, lock, v.e_lock);
    if (v.e_lock) begin
      chk({nm, ".lock_rd"}, lock_rd, v.rd);
      chk({nm, ".lock_tag"}, lock_robpos, v.tail);
    end
    chk({nm, ".robpos"}, issue_robpos, v.tail);
    chk({nm, ".push_rd"}, push_rd, v.rd);
    chk({nm, ".pc"}, push_pc, v.pc);
    chk({nm, ".imm"}, issue_imm, v.imm);
    if (v.mem) chk({nm, ".lsbpos"}, push_lsbpos, v.ltail);
    chk({nm, ".rj"}, issue_rj, v.e_rj);
    if (v.e_rj) chk({nm, ".vj"}, issue_vj, v.e_vj); else chk({nm, ".qj"}, issue_qj, v.e_qj);
    chk({nm, ".rk"}, issue_rk, v.e_rk);
    if (v.e_rk) chk({nm, ".vk"}, issue_vk, v.e_vk); else chk({nm, ".qk"}, issue_qk, v.e_qk);
  endtask

  // Full IDLE -> RESOLVE -> ISSUE -> IDLE pass with checks in every phase
  task automatic run_issue(input vec_t v, input string nm);
    logic e1, e2;
    @(negedge clk);
    scramble(); drive_instr(v); iq_valid = 1'b1;
    #1 chk({nm, ".pop"}, iq_pop, 1);
    @(negedge clk);
    drive_resolve(v);
    e1 = (v.rs1 != 0) && v.b1;
    e2 = (v.rs2 != 0) && v.b2;
    #1 chk({nm, ".getpos"}, getpos, 1);
    chk({nm, ".rf_idx1"}, rf_rs1_idx, v.rs1);
    chk({nm, ".rs1_flag"}, rs1_flag, e1);
    chk({nm, ".rs2_flag"}, rs2_flag, e2);
    if (e1) chk({nm, ".rs1_robpos"}, rs1_robpos, v.t1);
    if (e2) chk({nm, ".rs2_robpos"}, rs2_robpos, v.t2);
    @(negedge clk);
    scramble();
    alu_flag = v.bf[2]; alu_robpos = v.bt[2]; alu_val = v.bv[2];
    lsb_in_flag = v.bf[3]; lsb_robpos = v.bt[3]; lsb_val = v.bv[3];
    #1 check_issue(v, nm);
    @(negedge clk);
    alu_flag = 1'b0; lsb_in_flag = 1'b0;
    #1 chk({nm, ".push_done"}, push, 0);
  endtask

  initial begin
    vec_t v;
    int p0;
    reset = 1'b1; ready = 1'b1; clear = 1'b0; iq_valid = 1'b0; rob_full = 1'b0;
    rs_full = 1'b0; lsb_full = 1'b0;
    drive_instr(mk(6'd0, 0, 0, 0, 0, 0, 0));
    scramble();

    // Reset state
    @(negedge clk); @(negedge clk);
    #1 chk("rst.pop", iq_pop, 0);
    chk("rst.strobes", {getpos, rs1_flag, rs2_flag, push, rs_push, lsb_push, lock}, 0);
    reset = 1'b0;
    @(negedge clk);
    #1 chk("rst.latched", {lock_rd, lock_robpos, issue_robpos, push_lsbpos}, 0);
    chk("rst.push", push, 0);

    // Hand-derived vectors
    v = mk(OP_ADDI, 1, 0, 0, 5, 0, 0); v.tail = 6; v.b1 = 1; v.t1 = 5; v.v1 = 32'hdead;
    v.e_lock = 1; v.e_rj = 1; v.e_vj = 0; v.e_rk = 1; v.e_vk = 0; tbl[0] = v;
    v = mk(OP_ADD, 3, 1, 2, 0, 0, 0); v.tail = 7;
    v.b1 = 1; v.t1 = 2; v.ok1 = 1; v.f1 = 7; v.b2 = 1; v.t2 = 3; v.ok2 = 0;
    v.e_lock = 1; v.e_rj = 1; v.e_vj = 7; v.e_rk = 0; v.e_qk = 3; tbl[1] = v;
    v.bf[2] = 1; v.bt[2] = 3; v.bv[2] = 9; v.e_rk = 1; v.e_vk = 9; v.e_qk = 0; tbl[2] = v;
    v = mk(OP_SW, 5, 2, 5, 12, 1, 1); v.tail = 1; v.ltail = 9; v.v1 = 100; v.v2 = 55;
    v.e_lock = 0; v.e_rj = 1; v.e_vj = 100; v.e_rk = 1; v.e_vk = 55; tbl[3] = v;
    v = mk(OP_BEQ, 7, 4, 4, 32'hfffffff8, 0, 0); v.tail = 2;
    v.b1 = 1; v.t1 = 9; v.b2 = 1; v.t2 = 9;
    v.bf[1] = 1; v.bt[1] = 9; v.bv[1] = 33; v.bf[0] = 1; v.bt[0] = 8; v.bv[0] = 44;
    v.e_lock = 0; v.e_rj = 1; v.e_vj = 33; v.e_rk = 1; v.e_vk = 33; tbl[4] = v;
    v = mk(OP_JALR, 1, 6, 6, 0, 0, 0); v.tail = 3; v.b1 = 1; v.t1 = 5; v.b2 = 1; v.t2 = 5;
    v.bf[2] = 1; v.bt[2] = 5; v.bv[2] = 1; v.bf[3] = 1; v.bt[3] = 5; v.bv[3] = 2;
    v.e_lock = 1; v.e_rj = 1; v.e_vj = 1; v.e_rk = 1; v.e_vk = 1; tbl[5] = v;
    v = mk(OP_ADD, 0, 3, 4, 0, 0, 0); v.tail = 4; v.v1 = 11; v.b2 = 1; v.t2 = 1;
    v.bf[2] = 1; v.bt[2] = 2; v.bv[2] = 99;
    v.e_lock = 0; v.e_rj = 1; v.e_vj = 11; v.e_rk = 0; v.e_qk = 1; tbl[6] = v;
    v = mk(OP_LW, 8, 2, 0, 4, 1, 0); v.tail = 15; v.ltail = 15;
    v.b1 = 1; v.t1 = 15; v.ok1 = 1; v.f1 = 32'h1000;
    v.e_lock = 1; v.e_rj = 1; v.e_vj = 32'h1000; v.e_rk = 1; v.e_vk = 0; tbl[7] = v;
    for (int i = 0; i < 8; i++) run_issue(tbl[i], $sformatf("vec%0d", i));

    // Store blocked by a full LSB (RS full is irrelevant to it)
    @(negedge clk);
    drive_instr(tbl[3]); iq_valid = 1'b1; lsb_full = 1'b1; rs_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("lsbfull.pop", iq_pop, 0);
      @(negedge clk);
    end
    lsb_full = 1'b0; iq_valid = 1'b0;
    run_issue(tbl[3], "lsbfull_sw");
    // ALU op blocked by a full RS
    @(negedge clk);
    drive_instr(tbl[1]); iq_valid = 1'b1;
    #1 chk("rsfull.pop", iq_pop, 0);
    rs_full = 1'b0; iq_valid = 1'b0;

    // ROB full holds off popping
    @(negedge clk);
    drive_instr(tbl[0]); iq_valid = 1'b1; rob_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("robfull.pop", iq_pop, 0);
      @(negedge clk);
    end
    rob_full = 1'b0;
    #1 chk("robfull.release", iq_pop, 1);
    iq_valid = 1'b0;

    // Flush during RESOLVE
    p0 = pop_cnt;
    @(negedge clk);
    drive_instr(tbl[1]); iq_valid = 1'b1;
    #1 chk("clr.pop", iq_pop, 1);
    @(negedge clk);
    drive_resolve(tbl[1]); iq_valid = 1'b1; clear = 1'b1;
    #1 chk("clr.getpos", getpos, 0);
    chk("clr.nopop", iq_pop, 0);
    chk("clr.flags", {rs1_flag, rs2_flag}, 0);
    @(negedge clk);
    clear = 1'b0; iq_valid = 1'b0;
    #1 chk("clr.push", {push, rs_push, lock}, 0);
    iq_valid = 1'b1;
    #1 chk("clr.idle", iq_pop, 1);
    iq_valid = 1'b0;
    chk("clr.popcnt", pop_cnt - p0, 1);
    // Flush in IDLE suppresses the pop
    @(negedge clk);
    iq_valid = 1'b1; clear = 1'b1;
    #1 chk("clr.idlepop", iq_pop, 0);
    clear = 1'b0; ready = 1'b0;
    #1 chk("notready.pop", iq_pop, 0);
    ready = 1'b1; iq_valid = 1'b0;

    // Freeze in ISSUE: push held, broadcasts ignored
    @(negedge clk);
    scramble(); drive_instr(tbl[1]); iq_valid = 1'b1;
    #1 chk("frz.pop", iq_pop, 1);
    @(negedge clk);
    drive_resolve(tbl[1]);
    #1 chk("frz.getpos", getpos, 1);
    @(negedge clk);
    scramble(); ready = 1'b0; alu_flag = 1'b1; alu_robpos = 4'd3; alu_val = 32'd77;
    for (int i = 0; i < 3; i++) begin
      #1 chk("frz.push", {push, rs_push, lock}, 0);
      @(negedge clk);
    end
    ready = 1'b1; alu_flag = 1'b0;
    #1 check_issue(tbl[1], "frz");
    @(negedge clk);
    #1 chk("frz.done", push, 0);

    // Asynchronous reset during ISSUE
    @(negedge clk);
    scramble(); drive_instr(tbl[0]); iq_valid = 1'b1;
    #1 chk("arst.pop", iq_pop, 1);
    @(negedge clk);
    drive_resolve(tbl[0]);
    @(negedge clk);
    scramble();
    #1 chk("arst.push_before", push, 1);
    reset = 1'b1;
    #1 chk("arst.push", {push, rs_push, lock}, 0);
    @(negedge clk);
    reset = 1'b0; drive_instr(tbl[1]); iq_valid = 1'b1;
    #1 chk("arst.idle", iq_pop, 1);
    iq_valid = 1'b0;

    // Random issues against the reference model
    for (int n = 0; n < 40; n++) begin
      v = mk(6'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
             ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
             ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
             $urandom, 1'($urandom_range(0, 2) == 0), 1'($urandom));
      if ($urandom_range(0, 3) == 0) v.rs2 = v.rs1;
      v.st = v.st & v.mem;
      v.tail = 4'($urandom); v.ltail = 4'($urandom);
      v.b1 = 1'($urandom); v.t1 = 4'($urandom_range(0, 3)); v.v1 = $urandom;
      v.ok1 = ($urandom_range(0, 3) == 0); v.f1 = $urandom;
      v.b2 = 1'($urandom); v.t2 = 4'($urandom_range(0, 3)); v.v2 = $urandom;
      v.ok2 = ($urandom_range(0, 3) == 0); v.f2 = $urandom;
      if (v.rs1 == v.rs2) begin v.b2 = v.b1; v.t2 = v.t1; v.v2 = v.v1; v.ok2 = v.ok1; v.f2 = v.f1; end
      for (int i = 0; i < 4; i++) begin
        v.bf[i] = ($urandom_range(0, 2) == 0);
        v.bt[i] = 4'($urandom_range(0, 3));
        v.bv[i] = $urandom;
      end
      run_issue(predict(v), $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
